// File: rtl/note_scheduler.sv
// Beat-driven note scheduler: issues periodic advance strobes to a random
// note generator, captures the resulting notes into a small FIFO and hands
// them to a consumer over a valid/ready handshake.
module note_scheduler #(
  parameter int TEMPO_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo_period,
  input  logic [5:0]         rng_note,
  output logic               rng_en,
  output logic               rng_pulse,
  output logic               note_valid,
  output logic [5:0]         note_data,
  input  logic               note_ready,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         beat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [TEMPO_W-1:0] period_q;
  logic [TEMPO_W-1:0] cnt_q;
  logic [TEMPO_W-1:0] period_sel;
  logic               cap_pend_q;
  logic               start_ok;

  logic [5:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic               push_drop;

  // Periods below two are clamped so a beat never lands in every cycle.
  assign period_sel = (tempo_period < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period;

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign note_valid = (count_q != '0);
  assign note_data  = note_valid ? mem[rd_ptr_q] : '0;
  assign pop        = note_valid && note_ready;
  // A pop in the same cycle frees the slot the capture needs.
  assign push_ok    = cap_pend_q && (!fifo_full || pop);
  assign push_drop  = cap_pend_q && fifo_full && !pop;

  // Next-state and per-state outputs.
  always_comb begin
    state_d   = state_q;
    rng_en    = 1'b0;
    rng_pulse = 1'b0;
    busy      = (state_q != IDLE);
    start_ok  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        rng_en    = 1'b1;
        rng_pulse = (cnt_q == '0);
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (!note_valid && !cap_pend_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, beat timer, beat counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      period_q   <= '0;
      cnt_q      <= '0;
      cap_pend_q <= 1'b0;
      beat_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_pend_q <= rng_pulse;
      if (start_ok) begin
        period_q <= period_sel;
        cnt_q    <= period_sel - TEMPO_W'(1);
        beat_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (state_q == RUN) begin
          cnt_q <= (cnt_q == '0) ? period_q - TEMPO_W'(1) : cnt_q - TEMPO_W'(1);
        end
        if (rng_pulse) beat_cnt <= beat_cnt + 8'd1;
        if (push_drop) overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rng_note;
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: a behavioural reference model with a
// note scoreboard queue, a table-driven tempo sequence and directed corner cases.
module tb_note_scheduler;

  localparam int TW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [TW-1:0] tempo_period;
  logic [5:0]    rng_note;
  logic          rng_en;
  logic          rng_pulse;
  logic          note_valid;
  logic [5:0]    note_data;
  logic          note_ready;
  logic          busy;
  logic          overflow;
  logic [7:0]    beat_cnt;

  note_scheduler #(.TEMPO_W(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .tempo_period(tempo_period), .rng_note(rng_note),
    .rng_en(rng_en), .rng_pulse(rng_pulse),
    .note_valid(note_valid), .note_data(note_data), .note_ready(note_ready),
    .busy(busy), .overflow(overflow), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;
  mst_t       m_state;
  int         m_P, m_phase, m_beat;
  bit         m_pend, m_ovf;
  logic [5:0] m_q[$];      // scoreboard: notes expected at the FIFO head, in order
  logic [5:0] popped[$];   // notes the DUT actually handed over

  typedef struct {
    logic          st;
    logic          rdy;
    logic [TW-1:0] tp;
    logic          pulse;
    logic          valid;
    logic [5:0]    data;
  } vec_t;
  vec_t vt[14];

  function automatic logic [5:0] note_of(input int c);
    return 6'((c * 5 + 17) % 64);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_pulse();
    return (m_state == M_RUN) && (m_phase == m_P);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_P = 2; m_phase = 0; m_beat = 0;
    m_pend = 0; m_ovf = 0; m_q.delete();
  endtask

  task automatic check_outputs();
    chk("rng_en", rng_en, m_state == M_RUN);
    chk("rng_pulse", rng_pulse, m_pulse());
    chk("busy", busy, m_state != M_IDLE);
    chk("note_valid", note_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("note_data", note_data, m_q[0]);
    chk("overflow", overflow, m_ovf);
    chk("beat_cnt", beat_cnt, m_beat);
  endtask

  task automatic model_step();
    bit   pulse = m_pulse();
    bit   valid = (m_q.size() != 0);
    bit   full  = (m_q.size() == DEPTH);
    bit   popv  = valid && note_ready;
    mst_t nst   = m_state;
    if (popv) void'(m_q.pop_front());
    if (m_pend) begin
      if (full && !popv) m_ovf = 1;
      else m_q.push_back(rng_note);
    end
    case (m_state)
      M_IDLE: if (start && !stop) begin
        nst = M_RUN; m_P = (tempo_period < 2) ? 2 : int'(tempo_period);
        m_phase = 1; m_beat = 0; m_ovf = 0;
      end
      M_RUN: begin
        m_phase = pulse ? 1 : m_phase + 1;
        if (pulse) m_beat = (m_beat + 1) % 256;
        if (stop) nst = M_DRAIN;
      end
      default: if (!valid && !m_pend) nst = M_IDLE;
    endcase
    m_pend  = pulse;
    m_state = nst;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance.
  task automatic tick(input logic s, input logic p, input logic r);
    start = s; stop = p; note_ready = r; rng_note = note_of(cyc);
    check_outputs();
    if (note_valid && note_ready) popped.push_back(note_data);
    model_step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; note_ready = 1'b0;
    #1;
    chk("rst_rng_en", rng_en, 0);
    chk("rst_rng_pulse", rng_pulse, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_note_data", note_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    model_reset();
    popped.delete();
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
  endtask

  task automatic drain_idle();
    int n = 0;
    tick(1'b0, 1'b1, 1'b1);
    while (m_state != M_IDLE && n < 60) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("idle_after_drain", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    tempo_period = 16'd4;
    rng_note = '0;
    do_reset();

    // Tempo 4 from cycle 0, consumer always ready; tempo change mid-run must not matter.
    for (int i = 0; i < 14; i++) begin
      vt[i].st    = (i == 0);
      vt[i].rdy   = 1'b1;
      vt[i].tp    = (i < 2) ? TW'(4) : TW'(7);
      vt[i].pulse = (i == 4 || i == 8 || i == 12);
      vt[i].valid = (i == 6 || i == 10);
      vt[i].data  = (i == 6) ? note_of(5) : (i == 10) ? note_of(9) : 6'd0;
    end
    for (int i = 0; i < 14; i++) begin
      tempo_period = vt[i].tp;
      chk("tbl_pulse", rng_pulse, vt[i].pulse);
      chk("tbl_valid", note_valid, vt[i].valid);
      if (vt[i].valid) chk("tbl_data", note_data, vt[i].data);
      tick(vt[i].st, 1'b0, vt[i].rdy);
    end
    drain_idle();

    // Degenerate tempos 0 and 1 behave as period 2.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      tempo_period = TW'(t);
      tick(1'b1, 1'b0, 1'b1);
      chk("short_tempo_no_pulse_c1", rng_pulse, 0);
      tick(1'b0, 1'b0, 1'b1);
      chk("short_tempo_pulse_c2", rng_pulse, 1);
      repeat (8) tick(1'b0, 1'b0, 1'b1);
      drain_idle();
    end

    // start and stop together in IDLE: nothing happens.
    do_reset();
    tick(1'b1, 1'b1, 1'b0);
    chk("start_stop_idle", busy, 0);

    // Overflow on the fifth beat with consumer stalled; first four kept in order.
    do_reset();
    tempo_period = 16'd2;
    tick(1'b1, 1'b0, 1'b0);
    repeat (11) tick(1'b0, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_beats", beat_cnt, 5);
    popped.delete();
    drain_idle();
    chk("ovf_pop_count", popped.size(), 5);
    if (popped.size() == 5) begin
      chk("ovf_pop0", popped[0], note_of(3));
      chk("ovf_pop1", popped[1], note_of(5));
      chk("ovf_pop2", popped[2], note_of(7));
      chk("ovf_pop3", popped[3], note_of(9));
      chk("ovf_pop4", popped[4], note_of(13));
    end

    // Full FIFO with push and pop in the same cycle: nothing lost, no overflow.
    do_reset();
    tempo_period = 16'd2;
    tick(1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("full_pushpop_no_ovf", overflow, 0);
    tick(1'b0, 1'b1, 1'b1);
    drain_idle();
    chk("full_pushpop_ovf_after", overflow, 0);
    chk("full_pushpop_count", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      chk("full_pushpop_order", popped[i], note_of(3 + 2 * i));

    // Stop in a beat cycle with two notes queued; pending capture still lands.
    do_reset();
    tempo_period = 16'd3;
    tick(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(m_pulse() && m_q.size() == 2) && n < 40) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    tick(1'b0, 1'b1, 1'b0);
    chk("drain_busy", busy, 1);
    chk("drain_rng_en", rng_en, 0);
    popped.delete();
    n = 0;
    while (m_state != M_IDLE && n < 40) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_pops", popped.size(), 3);
    chk("drain_idle_busy", busy, 0);

    // Reset mid-run with three notes queued, then a clean restart.
    do_reset();
    tempo_period = 16'd2;
    tick(1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_q.size() != 3 && n < 40) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    do_reset();
    tick(1'b1, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    chk("restart_beat", beat_cnt, 1);
    drain_idle();

    // Randomised consumer stalls and stray start requests while running.
    do_reset();
    tempo_period = 16'd3;
    tick(1'b1, 1'b0, 1'b0);
    repeat (120) tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    drain_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter: TEMPO_W, default 16, width of the beat-period field.
REQ-002 Parameter: DEPTH, default 4, note FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; begin scheduling when idle.
REQ-006 stop  input  1  level; end scheduling, drain FIFO.
REQ-007 tempo_period  input  TEMPO_W  cycles between beats; latched on start.
REQ-008 rng_note  input  6  current note from the random note generator.
REQ-009 rng_en  output  1  generator enable; high only in RUN.
REQ-010 rng_pulse  output  1  one-cycle generator advance strobe.
REQ-011 note_valid  output  1  FIFO head holds a note.
REQ-012 note_data  output  6  FIFO head note.
REQ-013 note_ready  input  1  consumer accepts head when note_valid high.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 overflow  output  1  sticky: note dropped on full FIFO.
REQ-016 beat_cnt  output  8  count of issued beats.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-018 IDLE: start=1 and stop=0 -> RUN; latch P = max(tempo_period, 2); load down-counter with P-1; clear beat_cnt and overflow.
REQ-019 RUN: counter decrements each cycle; when counter==0, rng_pulse=1 that cycle and counter reloads P-1 -> one pulse every P cycles, first in the P-th RUN cycle.
REQ-020 rng_en=1 for every RUN cycle, 0 in IDLE and DRAIN; rng_pulse never high outside RUN.
REQ-021 Capture: cycle after rng_pulse, rng_note is pushed into FIFO at that cycle's clock edge; note_valid visible the following cycle (2 cycles after pulse cycle).
REQ-022 beat_cnt increments by 1 per rng_pulse, wraps 255 -> 0.
REQ-023 RUN: stop=1 -> DRAIN; no further pulses; a capture pending from a pulse in the stop cycle still completes.
REQ-024 DRAIN -> IDLE when FIFO empty and no capture pending.
REQ-025 start in RUN or DRAIN ignored; start and stop both high in IDLE: stay IDLE.
REQ-026 tempo_period changes while busy have no effect until next start.
REQ-027 FIFO: pop when note_valid and note_ready; note_data = oldest entry; order preserved.
REQ-028 Push when full and no pop same cycle: note dropped, overflow set, FIFO unchanged.
REQ-029 Push when full with pop same cycle: both succeed, count unchanged, no overflow.
REQ-030 Push when empty: note not bypassed; note_valid rises next cycle.
REQ-031 note_ready with note_valid=0: no effect; pointers wrap modulo DEPTH.
REQ-032 overflow clears only on accepted start or reset.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 rst=1 at any time, including mid-RUN or mid-DRAIN: state IDLE, FIFO empty, pending capture discarded, counter 0.
REQ-035 Reset values: rng_en=0, rng_pulse=0, note_valid=0, note_data=0, busy=0, overflow=0, beat_cnt=0.
REQ-036 First start honoured on the first rising edge after rst deasserts.

Verification
REQ-037 P=4, start high cycle 0, note_ready=1 -> rng_pulse in cycles 4, 8, 12; note_valid first high cycle 6 with note_data = rng_note value of cycle 5.
REQ-038 tempo_period=0 or 1 -> pulses every 2 cycles, first pulse cycle 2 after start.
REQ-039 P=2, note_ready=0, DEPTH=4 -> 4 notes stored, 5th beat sets overflow, FIFO keeps first 4 in order; note_ready=1 then pops 4 notes in issue order.
REQ-040 FIFO full, push and pop same cycle -> count stays 4, overflow stays 0, head advances.
REQ-041 stop asserted in a pulse cycle with 2 notes queued, note_ready=0 -> DRAIN, busy=1, rng_en=0; after 3 pops (incl. pending capture) -> IDLE, busy=0 next cycle.
REQ-042 rst pulsed mid-RUN with 3 notes queued -> all outputs at reset values immediately; subsequent start restarts beat_cnt from 0.
